// File: rtl/ts_host_port_if.sv
// Host/core signal bundle for ts_host_port. The block itself takes the slave view;
// the host/core environment takes the master view.
interface ts_host_port_if;
  logic        go;
  logic        done;
  logic        wr;
  logic [31:0] in_record;
  logic        full;
  logic        rd;
  logic        empty;
  logic [31:0] out_record;
  logic [31:0] core_rec;
  logic        core_rec_valid;
  logic        core_rec_pop;
  logic        core_start;
  logic        core_finish;
  logic [31:0] core_out_rec;
  logic        core_out_valid;
  logic        core_out_ready;
  logic [15:0] cycle_count;
  logic        ovf_err;

  modport slave (
    input  go, wr, in_record, rd, core_rec_pop, core_finish, core_out_rec, core_out_valid,
    output done, full, empty, out_record, core_rec, core_rec_valid, core_start,
           core_out_ready, cycle_count, ovf_err
  );

  modport master (
    output go, wr, in_record, rd, core_rec_pop, core_finish, core_out_rec, core_out_valid,
    input  done, full, empty, out_record, core_rec, core_rec_valid, core_start,
           core_out_ready, cycle_count, ovf_err
  );
endinterface

// File: rtl/ts_host_port.sv
// Host port for the timing-simulation core: input record FIFO, output record FIFO,
// and an IDLE/RUN/DRAIN run controller with a saturating RUN cycle counter.
module ts_host_port #(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  ts_host_port_if.slave  bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        core_start_q, core_start_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  logic [31:0]  in_mem_q [IN_DEPTH];
  logic [IAW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IAW:0] in_cnt_q, in_cnt_d;
  logic         in_full_q, in_full_d, in_empty_q, in_empty_d;
  logic         in_push, in_pop;

  logic [31:0]  out_mem_q [OUT_DEPTH];
  logic [OAW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OAW:0] out_cnt_q, out_cnt_d;
  logic         out_full_q, out_full_d, out_empty_q, out_empty_d;
  logic         out_push, out_pop;

  // A push into a full FIFO still lands when the same edge pops, so occupancy holds.
  always_comb begin
    in_pop   = bus.core_rec_pop && (state_q == RUN) && !in_empty_q;
    in_push  = bus.wr && (!in_full_q || in_pop);
    in_wr_d  = in_push ? in_wr_q + 1'b1 : in_wr_q;
    in_rd_d  = in_pop ? in_rd_q + 1'b1 : in_rd_q;
    in_cnt_d = in_cnt_q;
    if (in_push && !in_pop) in_cnt_d = in_cnt_q + 1'b1;
    else if (!in_push && in_pop) in_cnt_d = in_cnt_q - 1'b1;
    in_full_d  = in_cnt_d[IAW];
    in_empty_d = (in_cnt_d == '0);

    out_pop   = bus.rd && !out_empty_q;
    out_push  = bus.core_out_valid && (!out_full_q || out_pop);
    out_wr_d  = out_push ? out_wr_q + 1'b1 : out_wr_q;
    out_rd_d  = out_pop ? out_rd_q + 1'b1 : out_rd_q;
    out_cnt_d = out_cnt_q;
    if (out_push && !out_pop) out_cnt_d = out_cnt_q + 1'b1;
    else if (!out_push && out_pop) out_cnt_d = out_cnt_q - 1'b1;
    out_full_d  = out_cnt_d[OAW];
    out_empty_d = (out_cnt_d == '0);
  end

  always_comb begin
    state_d       = state_q;
    core_start_d  = 1'b0;
    cycle_count_d = cycle_count_q;
    ovf_d = ovf_q || (bus.wr && !in_push) || (bus.core_out_valid && !out_push);
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d       = RUN;
          core_start_d  = 1'b1;
          cycle_count_d = '0;
        end
      end
      RUN: begin
        if (cycle_count_q != 16'hFFFF) cycle_count_d = cycle_count_q + 1'b1;
        if (bus.core_finish) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_empty_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == IDLE) && out_empty_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      core_start_q  <= 1'b0;
      done_q        <= 1'b1;
      ovf_q         <= 1'b0;
      cycle_count_q <= '0;
      in_wr_q       <= '0;
      in_rd_q       <= '0;
      in_cnt_q      <= '0;
      in_full_q     <= 1'b0;
      in_empty_q    <= 1'b1;
      out_wr_q      <= '0;
      out_rd_q      <= '0;
      out_cnt_q     <= '0;
      out_full_q    <= 1'b0;
      out_empty_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      core_start_q  <= core_start_d;
      done_q        <= done_d;
      ovf_q         <= ovf_d;
      cycle_count_q <= cycle_count_d;
      in_wr_q       <= in_wr_d;
      in_rd_q       <= in_rd_d;
      in_cnt_q      <= in_cnt_d;
      in_full_q     <= in_full_d;
      in_empty_q    <= in_empty_d;
      out_wr_q      <= out_wr_d;
      out_rd_q      <= out_rd_d;
      out_cnt_q     <= out_cnt_d;
      out_full_q    <= out_full_d;
      out_empty_q   <= out_empty_d;
    end
  end

  // Storage needs no reset: pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_q] <= bus.in_record;
    if (out_push) out_mem_q[out_wr_q] <= bus.core_out_rec;
  end

  assign bus.done           = done_q;
  assign bus.full           = in_full_q;
  assign bus.empty          = out_empty_q;
  assign bus.out_record     = out_mem_q[out_rd_q];
  assign bus.core_rec       = in_mem_q[in_rd_q];
  assign bus.core_rec_valid = (state_q == RUN) && !in_empty_q;
  assign bus.core_start     = core_start_q;
  assign bus.core_out_ready = !out_full_q;
  assign bus.cycle_count    = cycle_count_q;
  assign bus.ovf_err        = ovf_q;
endmodule

// File: tb/tb_ts_host_port.sv
// Directed bench for ts_host_port: a table of single-cycle vectors for the main run
// flow, plus hand-written sequences for FIFO full/wrap, reset and ignored requests.
module tb_ts_host_port;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ts_host_port_if bus();
  ts_host_port #(.IN_DEPTH(16), .OUT_DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic go, wr; logic [31:0] in_rec; logic rd, pop, fin, cvalid; logic [31:0] crec;
    logic e_done, e_full, e_empty, e_valid, e_start, e_ready, e_ovf;
    logic [15:0] e_cnt; logic [31:0] e_core_rec, e_out_rec;
  } vec_t;

  function automatic vec_t mk(input logic go, wr, input logic [31:0] in_rec,
                              input logic rd, pop, fin, cvalid, input logic [31:0] crec,
                              input logic e_done, e_full, e_empty, e_valid, e_start,
                              input logic e_ready, e_ovf, input logic [15:0] e_cnt,
                              input logic [31:0] e_core_rec, e_out_rec);
    vec_t v;
    v.go = go; v.wr = wr; v.in_rec = in_rec; v.rd = rd; v.pop = pop; v.fin = fin;
    v.cvalid = cvalid; v.crec = crec; v.e_done = e_done; v.e_full = e_full;
    v.e_empty = e_empty; v.e_valid = e_valid; v.e_start = e_start; v.e_ready = e_ready;
    v.e_ovf = e_ovf; v.e_cnt = e_cnt; v.e_core_rec = e_core_rec; v.e_out_rec = e_out_rec;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.go = 1'b0; bus.wr = 1'b0; bus.in_record = 32'h0; bus.rd = 1'b0;
    bus.core_rec_pop = 1'b0; bus.core_finish = 1'b0;
    bus.core_out_valid = 1'b0; bus.core_out_rec = 32'h0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'h0, actual}, {31'h0, expected});
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.go = v.go; bus.wr = v.wr; bus.in_record = v.in_rec; bus.rd = v.rd;
    bus.core_rec_pop = v.pop; bus.core_finish = v.fin;
    bus.core_out_valid = v.cvalid; bus.core_out_rec = v.crec;
    tick();
  endtask

  task automatic check_vec(input int i, input vec_t v);
    checkFlag($sformatf("v%0d done", i), bus.done, v.e_done);
    checkFlag($sformatf("v%0d full", i), bus.full, v.e_full);
    checkFlag($sformatf("v%0d empty", i), bus.empty, v.e_empty);
    checkFlag($sformatf("v%0d core_rec_valid", i), bus.core_rec_valid, v.e_valid);
    checkFlag($sformatf("v%0d core_start", i), bus.core_start, v.e_start);
    checkFlag($sformatf("v%0d core_out_ready", i), bus.core_out_ready, v.e_ready);
    checkFlag($sformatf("v%0d ovf_err", i), bus.ovf_err, v.e_ovf);
    checkOutput($sformatf("v%0d cycle_count", i), {16'h0, bus.cycle_count}, {16'h0, v.e_cnt});
    if (v.e_valid) checkOutput($sformatf("v%0d core_rec", i), bus.core_rec, v.e_core_rec);
    if (!v.e_empty) checkOutput($sformatf("v%0d out_record", i), bus.out_record, v.e_out_rec);
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkFlag({tag, " done"}, bus.done, 1'b1);
    checkFlag({tag, " full"}, bus.full, 1'b0);
    checkFlag({tag, " empty"}, bus.empty, 1'b1);
    checkFlag({tag, " core_start"}, bus.core_start, 1'b0);
    checkFlag({tag, " core_rec_valid"}, bus.core_rec_valid, 1'b0);
    checkFlag({tag, " core_out_ready"}, bus.core_out_ready, 1'b1);
    checkOutput({tag, " cycle_count"}, {16'h0, bus.cycle_count}, 32'h0);
    checkFlag({tag, " ovf_err"}, bus.ovf_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] model[$];
    logic [31:0] rec;
    logic [31:0] ra, rb, rc, rp, rq;

    ra = 32'h4001_0005; rb = 32'h0002_000A; rc = 32'h4003_0010;
    rp = 32'h8005_0001; rq = 32'hC006_0002;

    //            go wr in  rd pop fin cv crec | done full empty valid start ready ovf cnt core_rec out_rec
    vecs.push_back(mk(0, 1, ra, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 1, 0, 16'd0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, rb, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 1, 0, 16'd0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, rc, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 1, 0, 16'd0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 1, 1, 0, 16'd0, ra, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 1, 1, 0, 1, 0, 16'd1, rb, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 1, 1, 0, 1, 0, 16'd2, rc, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 0, 16'd3, 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 1, rp, 0, 0, 0, 0, 0, 1, 0, 16'd4, 32'h0, rp));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 1, 1, rq, 0, 0, 0, 0, 0, 1, 0, 16'd5, 32'h0, rp));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 16'd5, 32'h0, rp));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 16'd5, 32'h0, rp));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 16'd5, 32'h0, rq));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 0, 16'd5, 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 1, 0, 16'd5, 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 1, 0, 16'd5, 32'h0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 1, 0, 16'd5, 32'h0, 32'h0));

    drive_idle();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values("async reset");
    tick();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      check_vec(i, vecs[i]);
    end
    drive_idle();

    // go while already running must not restart; rd on an empty output FIFO is a no-op.
    do_reset();
    bus.wr = 1'b1; bus.in_record = ra; tick();
    bus.wr = 1'b0; bus.go = 1'b1; tick();
    checkFlag("first go core_start", bus.core_start, 1'b1);
    tick();
    checkFlag("second go core_start", bus.core_start, 1'b0);
    checkOutput("second go cycle_count", {16'h0, bus.cycle_count}, 32'd1);
    bus.go = 1'b0; bus.rd = 1'b1; tick();
    bus.rd = 1'b0;
    checkFlag("rd empty empty", bus.empty, 1'b1);
    checkFlag("rd empty ovf_err", bus.ovf_err, 1'b0);
    checkFlag("rd empty core_rec_valid", bus.core_rec_valid, 1'b1);
    checkOutput("rd empty core_rec", bus.core_rec, ra);
    checkOutput("rd empty cycle_count", {16'h0, bus.cycle_count}, 32'd2);
    checkFlag("rd empty done", bus.done, 1'b0);
    bus.core_finish = 1'b1; tick();
    bus.core_finish = 1'b0; tick();
    checkFlag("back to idle done", bus.done, 1'b1);

    // Input FIFO full, simultaneous push/pop when full, then an overflow drop.
    do_reset();
    model.delete();
    for (int i = 0; i < 16; i++) begin
      rec = 32'h1000_0000 + 32'(i);
      bus.wr = 1'b1; bus.in_record = rec; tick();
      model.push_back(rec);
      if (i == 14) checkFlag("fill 15 full", bus.full, 1'b0);
      if (i == 15) checkFlag("fill 16 full", bus.full, 1'b1);
    end
    bus.wr = 1'b0; bus.go = 1'b1; tick();
    bus.go = 1'b0;
    checkOutput("full head", bus.core_rec, 32'h1000_0000);
    bus.wr = 1'b1; bus.in_record = 32'h2000_00FF; bus.core_rec_pop = 1'b1; tick();
    void'(model.pop_front());
    model.push_back(32'h2000_00FF);
    bus.core_rec_pop = 1'b0;
    checkFlag("full push+pop full", bus.full, 1'b1);
    checkFlag("full push+pop ovf_err", bus.ovf_err, 1'b0);
    bus.in_record = 32'hDEAD_BEEF; tick();
    bus.wr = 1'b0;
    checkFlag("overflow full", bus.full, 1'b1);
    checkFlag("overflow ovf_err", bus.ovf_err, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checkFlag($sformatf("in drain %0d valid", k), bus.core_rec_valid, 1'b1);
      checkOutput($sformatf("in drain %0d core_rec", k), bus.core_rec, model[k]);
      bus.core_rec_pop = 1'b1; tick();
    end
    bus.core_rec_pop = 1'b0;
    checkFlag("in drained valid", bus.core_rec_valid, 1'b0);
    checkFlag("in drained full", bus.full, 1'b0);

    // Output FIFO held at 15 entries with push+pop every cycle across pointer wrap.
    do_reset();
    model.delete();
    for (int i = 0; i < 15; i++) begin
      rec = 32'h3000_0000 + 32'(i);
      bus.core_out_valid = 1'b1; bus.core_out_rec = rec; tick();
      model.push_back(rec);
    end
    checkFlag("out 15 ready", bus.core_out_ready, 1'b1);
    for (int j = 0; j < 20; j++) begin
      rec = 32'h3100_0000 + 32'(j);
      checkOutput($sformatf("wrap %0d out_record", j), bus.out_record, model[0]);
      bus.core_out_rec = rec; bus.rd = 1'b1; tick();
      void'(model.pop_front());
      model.push_back(rec);
      checkFlag($sformatf("wrap %0d ready", j), bus.core_out_ready, 1'b1);
    end
    bus.rd = 1'b0; bus.core_out_rec = 32'h3200_0000; tick();
    model.push_back(32'h3200_0000);
    checkFlag("out 16 ready", bus.core_out_ready, 1'b0);
    checkFlag("out 16 ovf_err", bus.ovf_err, 1'b0);
    bus.core_out_rec = 32'hBAD0_0000; tick();
    bus.core_out_valid = 1'b0;
    checkFlag("out overflow ovf_err", bus.ovf_err, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checkFlag($sformatf("out drain %0d empty", k), bus.empty, 1'b0);
      checkOutput($sformatf("out drain %0d out_record", k), bus.out_record, model[k]);
      bus.rd = 1'b1; tick();
    end
    bus.rd = 1'b0;
    checkFlag("out drained empty", bus.empty, 1'b1);
    checkFlag("out drained done", bus.done, 1'b1);

    // Reset mid-RUN discards both FIFOs; the first go afterwards starts cleanly.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.wr = 1'b1; bus.in_record = 32'h5000_0000 + 32'(i); tick();
    end
    bus.wr = 1'b0; bus.core_out_valid = 1'b1; bus.core_out_rec = rp; bus.go = 1'b1; tick();
    bus.core_out_valid = 1'b0; bus.go = 1'b0; bus.core_rec_pop = 1'b1; tick();
    bus.core_rec_pop = 1'b0;
    checkOutput("pre-reset cycle_count", {16'h0, bus.cycle_count}, 32'd1);
    rst = 1'b1;
    #2 check_reset_values("mid-run reset");
    tick();
    rst = 1'b0; bus.go = 1'b1; tick();
    bus.go = 1'b0;
    checkFlag("post-reset core_start", bus.core_start, 1'b1);
    checkFlag("post-reset core_rec_valid", bus.core_rec_valid, 1'b0);
    checkFlag("post-reset empty", bus.empty, 1'b1);
    checkFlag("post-reset done", bus.done, 1'b0);
    checkOutput("post-reset cycle_count", {16'h0, bus.cycle_count}, 32'd0);
    tick();
    checkFlag("post-reset start pulse ends", bus.core_start, 1'b0);
    checkOutput("post-reset cycle_count 1", {16'h0, bus.cycle_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
